// File: rtl/prbs_15_rx_checker.sv
// PRBS-15 receive checker: descrambles a serial bitstream, deserializes it LSB-first
// into bytes and tracks repetitions of a 4-byte pattern to declare lock.
//
// state | meaning
// S0    | expecting P0
// S1    | expecting P1
// S2    | expecting P2
// S3    | expecting P3
module prbs_15_rx_checker #(
  parameter logic [14:0] SEED = 15'h7FFF,
  parameter logic [7:0]  P0   = 8'hCC,
  parameter logic [7:0]  P1   = 8'hDD,
  parameter logic [7:0]  P2   = 8'hEE,
  parameter logic [7:0]  P3   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       valid_in,
  input  logic       frame_start,
  input  logic [2:0] n,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pattern_found,
  output logic       locked,
  output logic [7:0] match_count
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t      state;
  logic [14:0] lfsr;
  logic [14:0] lfsr_src;
  logic [6:0]  sr;
  logic [2:0]  bit_cnt;
  logic [2:0]  rep_cnt;
  logic [2:0]  rep_next;
  logic [2:0]  n_eff;
  logic [7:0]  exp_byte;
  logic [7:0]  byte_next;
  logic        fs;
  logic        k;
  logic        dbit;

  // A frame start re-seeds the keystream for the very bit that carries it.
  always_comb begin
    fs        = valid_in & frame_start;
    lfsr_src  = fs ? SEED : lfsr;
    k         = lfsr_src[14] ^ lfsr_src[13];
    dbit      = data_in ^ k;
    byte_next = {dbit, sr};
    n_eff     = (n == 3'd0) ? 3'd1 : n;
    rep_next  = (rep_cnt == 3'd7) ? 3'd7 : rep_cnt + 3'd1;
    exp_byte  = P0;
    case (state)
      S0: exp_byte = P0;
      S1: exp_byte = P1;
      S2: exp_byte = P2;
      S3: exp_byte = P3;
      default: exp_byte = P0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= SEED;
      sr         <= '0;
      bit_cnt    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (valid_in) begin
        lfsr <= {lfsr_src[13:0], k};
        sr   <= {dbit, sr[6:1]};
        if (fs) begin
          bit_cnt <= 3'd1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_out   <= byte_next;
            byte_valid <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S0;
      rep_cnt       <= '0;
      pattern_found <= 1'b0;
      locked        <= 1'b0;
      match_count   <= '0;
    end else begin
      pattern_found <= 1'b0;
      if (fs) begin
        state   <= S0;
        rep_cnt <= '0;
        locked  <= 1'b0;
      end else if (byte_valid) begin
        if (byte_out == exp_byte) begin
          case (state)
            S0: state <= S1;
            S1: state <= S2;
            S2: state <= S3;
            default: begin
              state         <= S0;
              pattern_found <= 1'b1;
              rep_cnt       <= rep_next;
              if (rep_next >= n_eff) locked <= 1'b1;
              if (match_count != 8'hFF) match_count <= match_count + 8'd1;
            end
          endcase
        end else begin
          // Overlap restart: a stray P0 can begin the next sequence.
          rep_cnt <= '0;
          state   <= (byte_out == P0) ? S1 : S0;
        end
      end
    end
  end

endmodule
